// File: rtl/rgb_pwm_sequencer.sv
// Six-colour RGB wheel sequencer: prescaled PWM dimming, per-colour dwell,
// in-phase or staggered colour assignment across NUM_LEDS LEDs.
module rgb_pwm_sequencer #(
    parameter int NUM_LEDS = 2,
    parameter int PWM_BITS = 4,
    parameter int DIV      = 2,
    parameter int HOLD     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [PWM_BITS-1:0] bright,
    output logic [NUM_LEDS-1:0] led_r,
    output logic [NUM_LEDS-1:0] led_g,
    output logic [NUM_LEDS-1:0] led_b,
    output logic [2:0]          color_idx,
    output logic                period_pulse
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

    logic [DIV_W-1:0]    div_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] bright_q;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                tick;
    logic                wrap;
    logic                pwm_on;
    logic [NUM_LEDS-1:0] r_nxt;
    logic [NUM_LEDS-1:0] g_nxt;
    logic [NUM_LEDS-1:0] b_nxt;

    // Offsets never exceed 5+7=12, so two conditional subtracts replace a modulo.
    function automatic logic [2:0] wrap6(input logic [3:0] v);
        logic [3:0] r;
        r = v;
        if (r >= 4'd6) r = r - 4'd6;
        if (r >= 4'd6) r = r - 4'd6;
        return r[2:0];
    endfunction

    function automatic logic [2:0] color_map(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b100;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b010;
            3'd3:    rgb = 3'b011;
            3'd4:    rgb = 3'b001;
            3'd5:    rgb = 3'b101;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

    assign tick   = en && (div_cnt == DIV_LAST);
    assign wrap   = tick && (pwm_cnt == PWM_MAX);
    assign pwm_on = (pwm_cnt < bright_q);

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        logic [2:0] led_idx;
        logic [2:0] rgb;
        assign led_idx  = mode ? wrap6({1'b0, color_idx} + 4'(i)) : color_idx;
        assign rgb      = color_map(led_idx);
        assign r_nxt[i] = en & rgb[2] & pwm_on;
        assign g_nxt[i] = en & rgb[1] & pwm_on;
        assign b_nxt[i] = en & rgb[0] & pwm_on;
    end

    // Timing state: everything holds while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            pwm_cnt   <= '0;
            hold_cnt  <= '0;
            bright_q  <= '0;
            color_idx <= 3'd0;
        end else if (en) begin
            if (tick) begin
                div_cnt <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (wrap) begin
                bright_q <= bright;
                if (hold_cnt == HOLD_LAST) begin
                    hold_cnt  <= '0;
                    color_idx <= (color_idx == 3'd5) ? 3'd0 : color_idx + 3'd1;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    // Output registers: one cycle behind the timing state.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r        <= '0;
            led_g        <= '0;
            led_b        <= '0;
            period_pulse <= 1'b0;
        end else begin
            led_r        <= r_nxt;
            led_g        <= g_nxt;
            led_b        <= b_nxt;
            period_pulse <= wrap;
        end
    end

endmodule
